// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V field extractor and immediate generator (R/I/S/B/U/J).
// One 32-bit instruction is accepted per valid/ready handshake. Decoded results sit behind
// a 2-entry skid buffer (main output register + skid register), so in_ready comes from a flop.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake, instr_word is the raw instruction
//   out_valid/out_ready   output handshake
//   imm                   sign-extended XLEN immediate (0 for R and illegal)
//   rs1, rs2, rd          register indices, always extracted raw
//   funct3, funct7        function fields, always extracted raw
//   fmt                   0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   illegal               opcode not recognised
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter bit          RV64_OPS = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam logic [2:0] FmtR   = 3'd0;
    localparam logic [2:0] FmtI   = 3'd1;
    localparam logic [2:0] FmtS   = 3'd2;
    localparam logic [2:0] FmtB   = 3'd3;
    localparam logic [2:0] FmtU   = 3'd4;
    localparam logic [2:0] FmtJ   = 3'd5;
    localparam logic [2:0] FmtIll = 3'd7;

    // RV64-only opcodes are never legal on a 32-bit datapath.
    localparam bit Rv64En = RV64_OPS && (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      fmt;
        logic            illegal;
    } dec_t;

    dec_t               dec;
    logic signed [31:0] imm32;

    always_comb begin
        dec        = '0;
        imm32      = '0;
        dec.rs1    = instr_word[19:15];
        dec.rs2    = instr_word[24:20];
        dec.rd     = instr_word[11:7];
        dec.funct3 = instr_word[14:12];
        dec.funct7 = instr_word[31:25];
        case (instr_word[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: dec.fmt = FmtI;
            7'b0011011: dec.fmt = Rv64En ? FmtI : FmtIll;
            7'b0100011: dec.fmt = FmtS;
            7'b1100011: dec.fmt = FmtB;
            7'b0110111, 7'b0010111: dec.fmt = FmtU;
            7'b1101111: dec.fmt = FmtJ;
            7'b0110011: dec.fmt = FmtR;
            7'b0111011: dec.fmt = Rv64En ? FmtR : FmtIll;
            default:    dec.fmt = FmtIll;
        endcase
        dec.illegal = (dec.fmt == FmtIll);
        // Every immediate fits in 32 bits; build it signed, then widen with sign extension.
        case (dec.fmt)
            FmtI: imm32 = 32'($signed(instr_word[31:20]));
            FmtS: imm32 = 32'($signed({instr_word[31:25], instr_word[11:7]}));
            FmtB: imm32 = 32'($signed({instr_word[31], instr_word[7], instr_word[30:25],
                                       instr_word[11:8], 1'b0}));
            FmtU: imm32 = $signed({instr_word[31:12], 12'b0});
            FmtJ: imm32 = 32'($signed({instr_word[31], instr_word[19:12], instr_word[20],
                                       instr_word[30:21], 1'b0}));
            default: imm32 = '0;
        endcase
        dec.imm = XLEN'(imm32);
    end

    dec_t main_q, main_d, skid_q, skid_d;
    logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic accept, pop;

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign accept    = in_valid && in_ready;
    assign pop       = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (pop) begin
            // accept cannot coincide with a full skid since in_ready is low then.
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign imm     = main_q.imm;
    assign rs1     = main_q.rs1;
    assign rs2     = main_q.rs2;
    assign rd      = main_q.rd;
    assign funct3  = main_q.funct3;
    assign funct7  = main_q.funct7;
    assign fmt     = main_q.fmt;
    assign illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr_word = '0;

    always #5 clk = ~clk;

    // XLEN=32 instance
    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] imm_a;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [2:0]  funct3_a, fmt_a;
    logic [6:0]  funct7_a;

    // XLEN=64, RV64_OPS=1 instance, same stimulus
    logic        in_ready_b, out_valid_b, illegal_b;
    logic [63:0] imm_b;
    logic [4:0]  rs1_b, rs2_b, rd_b;
    logic [2:0]  funct3_b, fmt_b;
    logic [6:0]  funct7_b;

    imm_gen_pipe #(.XLEN(32), .RV64_OPS(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr_word(instr_word), .out_valid(out_valid_a), .out_ready(out_ready),
        .imm(imm_a), .rs1(rs1_a), .rs2(rs2_a), .rd(rd_a), .funct3(funct3_a),
        .funct7(funct7_a), .fmt(fmt_a), .illegal(illegal_a)
    );

    imm_gen_pipe #(.XLEN(64), .RV64_OPS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr_word(instr_word), .out_valid(out_valid_b), .out_ready(out_ready),
        .imm(imm_b), .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .funct3(funct3_b),
        .funct7(funct7_b), .fmt(fmt_b), .illegal(illegal_b)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [2:0]  fmt;
        logic        illegal;
    } exp_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the opcode table and immediate bit layouts, as 64-bit values.
    function automatic exp_t model_decode(input logic [31:0] w, input bit rv64);
        exp_t   e;
        longint v;
        e        = '0;
        e.rs1    = w[19:15];
        e.rs2    = w[24:20];
        e.rd     = w[11:7];
        e.funct3 = w[14:12];
        e.funct7 = w[31:25];
        v        = 0;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: e.fmt = 3'd1;
            7'b0011011: e.fmt = rv64 ? 3'd1 : 3'd7;
            7'b0100011: e.fmt = 3'd2;
            7'b1100011: e.fmt = 3'd3;
            7'b0110111, 7'b0010111: e.fmt = 3'd4;
            7'b1101111: e.fmt = 3'd5;
            7'b0110011: e.fmt = 3'd0;
            7'b0111011: e.fmt = rv64 ? 3'd0 : 3'd7;
            default:    e.fmt = 3'd7;
        endcase
        case (e.fmt)
            3'd1: v = $signed(w[31:20]);
            3'd2: v = $signed({w[31:25], w[11:7]});
            3'd3: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            3'd4: v = $signed({w[31:12], 12'b0});
            3'd5: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: v = 0;
        endcase
        e.imm     = v;
        e.illegal = (e.fmt == 3'd7);
        return e;
    endfunction

    task automatic check_lit(input logic [31:0] w, input bit rv64, input logic [2:0] f,
                             input logic [63:0] im);
        exp_t e;
        e = model_decode(w, rv64);
        check($sformatf("lit_%08h", w), 128'({e.fmt, e.illegal, e.imm}),
              128'({f, f == 3'd7, im}));
    endtask

    // Depth-2 FIFO view of the block: in_ready means fewer than two results held.
    exp_t qa[$];
    exp_t qb[$];
    exp_t last_a = '0;
    exp_t last_b = '0;
    exp_t ea, eb;
    bit   started = 0;
    bit   do_pop, do_push;

    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            last_a  = '0;
            last_b  = '0;
            started = 1;
        end else if (started) begin
            do_pop  = (qa.size() > 0) && out_ready;
            do_push = in_valid && (qa.size() < 2);
            if (do_pop) begin
                last_a = qa.pop_front();
                last_b = qb.pop_front();
            end
            if (do_push) begin
                qa.push_back(model_decode(instr_word, 1'b0));
                qb.push_back(model_decode(instr_word, 1'b1));
            end
        end
        #1;
        if (started) begin
            ea = (qa.size() > 0) ? qa[0] : last_a;
            eb = (qb.size() > 0) ? qb[0] : last_b;
            check("hs32", 128'({out_valid_a, in_ready_a}),
                  128'({qa.size() > 0, qa.size() < 2}));
            check("hs64", 128'({out_valid_b, in_ready_b}),
                  128'({qb.size() > 0, qb.size() < 2}));
            check("data32",
                  128'({imm_a, rs1_a, rs2_a, rd_a, funct3_a, funct7_a, fmt_a, illegal_a}),
                  128'({ea.imm[31:0], ea.rs1, ea.rs2, ea.rd, ea.funct3, ea.funct7, ea.fmt,
                        ea.illegal}));
            check("data64",
                  128'({imm_b, rs1_b, rs2_b, rd_b, funct3_b, funct7_b, fmt_b, illegal_b}),
                  128'({eb.imm, eb.rs1, eb.rs2, eb.rd, eb.funct3, eb.funct7, eb.fmt,
                        eb.illegal}));
        end
    end

    task automatic drive(input logic [31:0] w, input logic v, input logic r, input logic rs);
        @(negedge clk);
        instr_word = w;
        in_valid   = v;
        out_ready  = r;
        rst        = rs;
    endtask

    logic [31:0] directed [12] = '{
        32'h00512423, 32'hFE512E23, 32'hFE000CE3, 32'h123450B7, 32'h001000EF,
        32'hFFF00093, 32'h00B50533, 32'h0000007F, 32'h8000003B, 32'h800000B7,
        32'h0000001B, 32'hFFFFF017
    };
    logic [6:0] ops [12] = '{
        7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0011011, 7'b0100011,
        7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011
    };

    initial begin
        logic [31:0] rw;
        int unsigned pick;

        // Pin the model against hand-computed values.
        check_lit(32'h00512423, 1'b0, 3'd2, 64'h0000000000000008);
        check_lit(32'hFE512E23, 1'b0, 3'd2, 64'hFFFFFFFFFFFFFFFC);
        check_lit(32'hFE000CE3, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFF8);
        check_lit(32'h123450B7, 1'b0, 3'd4, 64'h0000000012345000);
        check_lit(32'h001000EF, 1'b0, 3'd5, 64'h0000000000000800);
        check_lit(32'hFFF00093, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF);
        check_lit(32'h00B50533, 1'b0, 3'd0, 64'h0);
        check_lit(32'h0000007F, 1'b0, 3'd7, 64'h0);
        check_lit(32'h8000003B, 1'b1, 3'd0, 64'h0);
        check_lit(32'h8000003B, 1'b0, 3'd7, 64'h0);
        check_lit(32'h800000B7, 1'b1, 3'd4, 64'hFFFFFFFF80000000);
        check_lit(32'hFFF0001B, 1'b1, 3'd1, 64'hFFFFFFFFFFFFFFFF);

        // Reset
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 1'b1);

        // Directed decode, full-rate with out_ready=1
        for (int i = 0; i < 12; i++) drive(directed[i], 1'b1, 1'b1, 1'b0);
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        drive(32'h0, 1'b0, 1'b1, 1'b0);

        // Backpressure: 4 offered while stalled, only 2 fit
        for (int i = 0; i < 4; i++) drive(directed[i + 2], 1'b1, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(32'h0, 1'b0, 1'b1, 1'b0);

        // Throughput: 16 back to back
        for (int i = 0; i < 16; i++) begin
            rw = $urandom();
            rw[6:0] = ops[i % 12];
            drive(rw, 1'b1, 1'b1, 1'b0);
        end
        drive(32'h0, 1'b0, 1'b1, 1'b0);

        // Reset with both entries full, then confirm nothing stale emerges
        drive(32'h00512423, 1'b1, 1'b0, 1'b0);
        drive(32'hFE000CE3, 1'b1, 1'b0, 1'b0);
        drive(32'h123450B7, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(32'h0, 1'b0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rw   = $urandom();
            pick = $urandom_range(0, 13);
            if (pick < 12) rw[6:0] = ops[pick];
            drive(rw, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 149) == 0);
        end

        for (int i = 0; i < 5; i++) drive(32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
